// File: rtl/uart_bus_arbiter_if.sv
// Bus bundle for uart_bus_arbiter: two master request/return ports, the
// forwarded UART register-bus port and the debug grant vector.
// Ports (per master N): mN_addr/mN_wdata/mN_we/mN_stb toward the arbiter,
// mN_rdata/mN_ack/mN_err back. UART side: s_addr/s_wdata/s_we/s_stb out,
// s_rdata/s_ack in. grant: one-hot owner, 00 when idle.
// modport master: arbiter view (it masters the UART bus).
// modport slave: environment view (bus masters and UART slave).
interface uart_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_we;
    logic              m0_stb;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;
    logic              m0_err;

    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_we;
    logic              m1_stb;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;
    logic              m1_err;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_we;
    logic              s_stb;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ack;

    logic [1:0]        grant;

    modport master (
        input  m0_addr, m0_wdata, m0_we, m0_stb,
        input  m1_addr, m1_wdata, m1_we, m1_stb,
        input  s_rdata, s_ack,
        output m0_rdata, m0_ack, m0_err,
        output m1_rdata, m1_ack, m1_err,
        output s_addr, s_wdata, s_we, s_stb,
        output grant
    );

    modport slave (
        output m0_addr, m0_wdata, m0_we, m0_stb,
        output m1_addr, m1_wdata, m1_we, m1_stb,
        output s_rdata, s_ack,
        input  m0_rdata, m0_ack, m0_err,
        input  m1_rdata, m1_ack, m1_err,
        input  s_addr, s_wdata, s_we, s_stb,
        input  grant
    );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of the UART register bus.
// Registered forwarding of the winner's request to the UART, per-master
// ack/err/rdata return, and a bus timeout that aborts a stuck access.
// Ports: clk (rising edge), reset (async, active high),
//        bus (uart_bus_arbiter_if.master: m0_*/m1_* masters, s_* UART, grant).
module uart_bus_arbiter #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_bus_arbiter_if.master     bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              s_we_q, s_we_d;
    logic              s_stb_q, s_stb_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;      // 1 = m1 owned the last grant
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              m0_err_q, m0_err_d;
    logic              m1_err_q, m1_err_d;

    logic              sel_c;               // winner in IDLE: 1 = m1
    logic [CNT_W-1:0]  cnt_inc_c;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_we_q     <= 1'b0;
            s_stb_q    <= 1'b0;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_we_q     <= s_we_d;
            s_stb_q    <= s_stb_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_we_d     = s_we_q;
        s_stb_d    = s_stb_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;

        // On a tie the master that did not win last time takes the bus
        sel_c     = (bus.m0_stb && bus.m1_stb) ? ~last_q : bus.m1_stb;
        cnt_inc_c = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.m0_stb || bus.m1_stb) begin
                    s_addr_d  = sel_c ? bus.m1_addr  : bus.m0_addr;
                    s_wdata_d = sel_c ? bus.m1_wdata : bus.m0_wdata;
                    s_we_d    = sel_c ? bus.m1_we    : bus.m0_we;
                    s_stb_d   = 1'b1;
                    grant_d   = sel_c ? 2'b10 : 2'b01;
                    last_d    = sel_c;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc_c;
                // Ack is checked first so it wins over a same-cycle timeout
                if (bus.s_ack) begin
                    if (last_q) begin
                        m1_rdata_d = bus.s_rdata;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = bus.s_rdata;
                        m0_ack_d   = 1'b1;
                    end
                    s_stb_d = 1'b0;
                    grant_d = 2'b00;
                    state_d = DONE;
                end else if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
                    if (last_q) begin
                        m1_rdata_d = '0;
                        m1_err_d   = 1'b1;
                    end else begin
                        m0_rdata_d = '0;
                        m0_err_d   = 1'b1;
                    end
                    s_stb_d = 1'b0;
                    grant_d = 2'b00;
                    state_d = DONE;
                end
            end
            DONE: begin
                // One dead cycle lets the served master drop its strobe
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_stb_d = 1'b0;
                grant_d = 2'b00;
            end
        endcase
    end

    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_stb    = s_stb_q;
    assign bus.grant    = grant_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m1_err   = m1_err_q;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed self-checking bench for uart_bus_arbiter.
module tb_uart_bus_arbiter;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   stb_cycles;

    uart_bus_arbiter_if #(.ADDR_W(2), .DATA_W(8)) bus ();

    uart_bus_arbiter #(.ADDR_W(2), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_we = 1'b0; bus.m0_stb = 1'b0;
        bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_we = 1'b0; bus.m1_stb = 1'b0;
        bus.s_rdata = '0; bus.s_ack = 1'b0;
        tick();
        tick();
        check("rst_s_stb", 32'(bus.s_stb), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_acks",  32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 32'd0);
        reset = 1'b0;
        tick();

        // Single write from m0, UART acks in cycle 3
        bus.m0_addr = 2'b00; bus.m0_wdata = 8'h41; bus.m0_we = 1'b1; bus.m0_stb = 1'b1;
        tick();
        check("wr_c1_stb",   32'(bus.s_stb),   32'd1);
        check("wr_c1_addr",  32'(bus.s_addr),  32'd0);
        check("wr_c1_wdata", 32'(bus.s_wdata), 32'h41);
        check("wr_c1_we",    32'(bus.s_we),    32'd1);
        check("wr_c1_grant", 32'(bus.grant),   32'b01);
        tick();
        check("wr_c2_stb", 32'(bus.s_stb), 32'd1);
        tick();
        check("wr_c3_stb", 32'(bus.s_stb), 32'd1);
        check("wr_c3_ack_early", 32'(bus.m0_ack), 32'd0);
        bus.s_ack = 1'b1;
        tick();
        check("wr_c4_ack",   32'(bus.m0_ack), 32'd1);
        check("wr_c4_stb",   32'(bus.s_stb),  32'd0);
        check("wr_c4_grant", 32'(bus.grant),  32'd0);
        check("wr_c4_m1",    32'({bus.m1_ack, bus.m1_err}), 32'd0);
        bus.s_ack = 1'b0; bus.m0_stb = 1'b0;
        tick();
        check("wr_c5_ack_pulse", 32'(bus.m0_ack), 32'd0);
        tick();

        // Read by m1 returning 0x5A
        bus.m1_addr = 2'b01; bus.m1_we = 1'b0; bus.m1_stb = 1'b1;
        tick();
        check("rd_grant", 32'(bus.grant),  32'b10);
        check("rd_addr",  32'(bus.s_addr), 32'd1);
        check("rd_we",    32'(bus.s_we),   32'd0);
        bus.s_ack = 1'b1; bus.s_rdata = 8'h5A;
        tick();
        check("rd_ack",      32'(bus.m1_ack),   32'd1);
        check("rd_rdata",    32'(bus.m1_rdata), 32'h5A);
        check("rd_m0_rdata", 32'(bus.m0_rdata), 32'h00);
        check("rd_m0_ack",   32'(bus.m0_ack),   32'd0);
        bus.s_ack = 1'b0; bus.m1_stb = 1'b0;
        tick();
        check("rd_ack_pulse", 32'(bus.m1_ack), 32'd0);

        // Fresh reset, then both masters request continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.m0_we = 1'b0; bus.m1_we = 1'b0;
        bus.m0_stb = 1'b1; bus.m1_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr%0d_grant", i), 32'(bus.grant), (i % 2 == 0) ? 32'b01 : 32'b10);
            bus.s_ack = 1'b1;
            tick();
            check($sformatf("rr%0d_acks", i), 32'({bus.m1_ack, bus.m0_ack}),
                  (i % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("rr%0d_done_grant", i), 32'(bus.grant), 32'd0);
            bus.s_ack = 1'b0;
            tick();
        end
        bus.m0_stb = 1'b0; bus.m1_stb = 1'b0;
        tick();
        check("rr_idle_grant", 32'(bus.grant), 32'd0);

        // Timeout: UART never acks a read from m0
        check("to_pre_rdata", 32'(bus.m0_rdata), 32'h5A);
        bus.m0_addr = 2'b11; bus.m0_stb = 1'b1;
        tick();
        stb_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.s_stb) break;
            stb_cycles++;
            tick();
        end
        check("to_stb_cycles", 32'(stb_cycles),   32'd15);
        check("to_err",        32'(bus.m0_err),   32'd1);
        check("to_ack",        32'(bus.m0_ack),   32'd0);
        check("to_rdata",      32'(bus.m0_rdata), 32'h00);
        check("to_m1_err",     32'(bus.m1_err),   32'd0);
        bus.m0_stb = 1'b0;
        tick();
        check("to_err_pulse", 32'(bus.m0_err), 32'd0);
        tick();
        bus.m0_stb = 1'b1;
        tick();
        check("to_next_grant", 32'(bus.grant), 32'b01);
        bus.s_ack = 1'b1; bus.s_rdata = 8'h33;
        tick();
        check("to_next_ack",   32'(bus.m0_ack),   32'd1);
        check("to_next_rdata", 32'(bus.m0_rdata), 32'h33);
        bus.s_ack = 1'b0; bus.m0_stb = 1'b0;
        tick();
        tick();

        // Ack lands on the same cycle the counter reaches TIMEOUT
        bus.m0_stb = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("col_stb_c15", 32'(bus.s_stb), 32'd1);
        bus.s_ack = 1'b1; bus.s_rdata = 8'h77;
        tick();
        check("col_ack",   32'(bus.m0_ack),   32'd1);
        check("col_err",   32'(bus.m0_err),   32'd0);
        check("col_rdata", 32'(bus.m0_rdata), 32'h77);
        bus.s_ack = 1'b0; bus.m0_stb = 1'b0;
        tick();
        tick();

        // Reset during ACCESS clears outputs without a clock edge
        bus.m1_stb = 1'b1;
        tick();
        check("rst_mid_grant_pre", 32'(bus.grant), 32'b10);
        reset = 1'b1;
        #1;
        check("rst_mid_stb",   32'(bus.s_stb), 32'd0);
        check("rst_mid_grant", 32'(bus.grant), 32'd0);
        check("rst_mid_flags", 32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 32'd0);
        tick();
        reset = 1'b0;
        bus.m0_stb = 1'b1; bus.m1_stb = 1'b1;
        tick();
        check("rst_tie_grant", 32'(bus.grant), 32'b01);
        bus.m0_stb = 1'b0; bus.m1_stb = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
